// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared state encodings, game constants and the saturating
//               score adder used by the game controller.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_SERVE   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_LOST    = 3'd3,
        ST_OVER    = 3'd4,
        ST_WON     = 3'd5
    } state_t;

    localparam int C_LIVES_INIT  = 3;
    localparam int C_SCREEN_H    = 480;
    localparam int C_BALL_SIZE   = 7;
    localparam int C_BRICK_COUNT = 20;
    localparam int C_SERVE_DELAY = 60;

    localparam logic [11:0] C_SCORE_HIT     = 12'd1;
    localparam logic [11:0] C_SCORE_DESTROY = 12'd5;
    localparam logic [11:0] C_SCORE_MAX     = 12'd4095;

    // Score addition that pins at the maximum instead of wrapping
    function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[12] ? C_SCORE_MAX : sum[11:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : One-clock pulse on a rising edge of d. The history register
//               resets high so a level held through reset is not an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic prev_q;

    // Remember last cycle's input level
    always_ff @(posedge clk) begin
        if (reset) prev_q <= 1'b1;
        else       prev_q <= d;
    end

    assign pulse = d & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl
// Description : Breakout-style game sequencer: start/serve handshake with the
//               ball datapath, hit scoring, life tracking and win/lose states.
// Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT  = C_LIVES_INIT,
    parameter int SCREEN_H    = C_SCREEN_H,
    parameter int BALL_SIZE   = C_BALL_SIZE,
    parameter int BRICK_COUNT = C_BRICK_COUNT,
    parameter int SERVE_DELAY = C_SERVE_DELAY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        tick,
    input  logic [9:0]  ball_y,
    input  logic        erase_enable,
    input  logic [1:0]  active_data,
    output logic        ball_reset,
    output logic        ball_start,
    output logic [1:0]  lives,
    output logic [11:0] score,
    output logic [2:0]  state,
    output logic        life_lost,
    output logic        game_won,
    output logic        game_over
);

    localparam int          CNT_W  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [10:0] LOST_Y = 11'(SCREEN_H - BALL_SIZE);

    state_t            state_q, state_d;
    logic [1:0]        lives_q, lives_d;
    logic [11:0]       score_q, score_d;
    logic [4:0]        cleared_q, cleared_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ball_reset_q, ball_reset_d;
    logic              ball_start_q, ball_start_d;
    logic              life_lost_q, life_lost_d;
    logic              game_won_q, game_won_d;
    logic              game_over_q, game_over_d;

    logic              w_start;
    logic              w_launch;
    logic              w_destroy;
    logic              w_ball_out;
    logic              w_hold_q, w_hold_d, w_idle_d;

    rise_detect u_start_edge (
        .clk   (clk),
        .reset (reset),
        .d     (btn_start),
        .pulse (w_start)
    );

    assign w_ball_out = ({1'b0, ball_y} > LOST_Y);

    // Next-state, scoring, life and serve-delay bookkeeping
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        score_d     = score_q;
        cleared_d   = cleared_q;
        cnt_d       = cnt_q;
        life_lost_d = 1'b0;
        w_launch    = 1'b0;
        w_destroy   = 1'b0;

        case (state_q)
            ST_ATTRACT: begin
                if (w_start) begin
                    lives_d   = 2'(LIVES_INIT);
                    score_d   = 12'd0;
                    cleared_d = 5'd0;
                    state_d   = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (w_start) begin
                    w_launch = 1'b1;
                    state_d  = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (erase_enable) begin
                        if (active_data == 2'd3) begin
                            score_d   = sat_add(score_q, C_SCORE_DESTROY);
                            cleared_d = cleared_q + 5'd1;
                            w_destroy = 1'b1;
                        end else if (active_data != 2'd0) begin
                            score_d = sat_add(score_q, C_SCORE_HIT);
                        end
                    end
                    // Clearing the wall beats a simultaneous ball loss
                    if (w_destroy && (cleared_d == 5'(BRICK_COUNT))) begin
                        state_d = ST_WON;
                    end else if (w_ball_out) begin
                        life_lost_d = 1'b1;
                        lives_d     = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                        cnt_d       = '0;
                        state_d     = ST_LOST;
                    end
                end
            end
            ST_LOST: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
                        cnt_d = '0;
                        if (lives_q == 2'd0) begin
                            state_d = ST_OVER;
                        end else begin
                            cleared_d = 5'd0;
                            state_d   = ST_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_OVER, ST_WON: begin
                if (w_start) state_d = ST_ATTRACT;
            end
            default: state_d = ST_ATTRACT;
        endcase
    end

    assign w_hold_q = (state_q == ST_ATTRACT) || (state_q == ST_LOST);
    assign w_hold_d = (state_d == ST_ATTRACT) || (state_d == ST_LOST);
    assign w_idle_d = (state_d == ST_OVER)    || (state_d == ST_WON);

    // Ball control strobes linger until the slower ball update has seen a tick
    always_comb begin
        ball_reset_d = w_hold_d | (~w_idle_d & ball_reset_q & ~(tick & ~w_hold_q));
        ball_start_d = w_launch | (ball_start_q & ~tick & (state_d == ST_PLAY));
        game_won_d   = (state_d == ST_WON);
        game_over_d  = (state_d == ST_OVER);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ATTRACT;
            lives_q      <= 2'(LIVES_INIT);
            score_q      <= 12'd0;
            cleared_q    <= 5'd0;
            cnt_q        <= '0;
            ball_reset_q <= 1'b1;
            ball_start_q <= 1'b0;
            life_lost_q  <= 1'b0;
            game_won_q   <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            cleared_q    <= cleared_d;
            cnt_q        <= cnt_d;
            ball_reset_q <= ball_reset_d;
            ball_start_q <= ball_start_d;
            life_lost_q  <= life_lost_d;
            game_won_q   <= game_won_d;
            game_over_q  <= game_over_d;
        end
    end

    assign state      = state_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign ball_reset = ball_reset_q;
    assign ball_start = ball_start_q;
    assign life_lost  = life_lost_q;
    assign game_won   = game_won_q;
    assign game_over  = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_game_ctrl
// Description : Self-checking bench for game_ctrl with a behavioural model,
//               directed game scenarios and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_start = 1'b0;
    logic        tick = 1'b0;
    logic [9:0]  ball_y = 10'd100;
    logic        erase_enable = 1'b0;
    logic [1:0]  active_data = 2'd0;
    logic        ball_reset, ball_start, life_lost, game_won, game_over;
    logic [1:0]  lives;
    logic [11:0] score;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .btn_start    (btn_start),
        .tick         (tick),
        .ball_y       (ball_y),
        .erase_enable (erase_enable),
        .active_data  (active_data),
        .ball_reset   (ball_reset),
        .ball_start   (ball_start),
        .lives        (lives),
        .score        (score),
        .state        (state),
        .life_lost    (life_lost),
        .game_won     (game_won),
        .game_over    (game_over)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: game rules as plain integer bookkeeping
    int m_state, m_lives, m_score, m_cleared, m_ticks;
    bit m_prev, m_br, m_bs, m_ll, m_valid = 0;

    always @(posedge clk) begin : model
        bit start, launched, destroyed;
        int old;
        if (reset) begin
            m_state = 0; m_lives = 3; m_score = 0; m_cleared = 0; m_ticks = 0;
            m_prev = 1; m_br = 1; m_bs = 0; m_ll = 0; m_valid = 1;
        end else if (m_valid) begin
            start    = btn_start && !m_prev;
            m_prev   = btn_start;
            m_ll     = 0;
            launched = 0;
            old      = m_state;
            case (m_state)
                0: if (start) begin m_lives = 3; m_score = 0; m_cleared = 0; m_state = 1; end
                1: if (start) begin launched = 1; m_state = 2; end
                2: if (tick) begin
                    destroyed = 0;
                    if (erase_enable && active_data == 3) begin
                        m_score = (m_score + 5 > 4095) ? 4095 : m_score + 5;
                        m_cleared++;
                        destroyed = 1;
                    end else if (erase_enable && active_data != 0) begin
                        m_score = (m_score + 1 > 4095) ? 4095 : m_score + 1;
                    end
                    if (destroyed && m_cleared == 20) m_state = 5;
                    else if (ball_y > 480 - 7) begin
                        m_ll = 1;
                        if (m_lives > 0) m_lives--;
                        m_ticks = 0;
                        m_state = 3;
                    end
                end
                3: if (tick) begin
                    m_ticks++;
                    if (m_ticks == 60) begin
                        m_ticks = 0;
                        if (m_lives == 0) m_state = 4;
                        else begin m_state = 1; m_cleared = 0; end
                    end
                end
                default: if (start) m_state = 0;
            endcase
            // ball_reset: on while waiting/attracting, off in end states, else released after a tick outside them
            if (m_state == 0 || m_state == 3)      m_br = 1;
            else if (m_state == 4 || m_state == 5) m_br = 0;
            else if (tick && !(old == 0 || old == 3)) m_br = 0;
            // ball_start: from launch until the first tick seen in play
            if (launched) m_bs = 1;
            else if (tick || m_state != 2) m_bs = 0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("state",      state,      m_state);
            chk("lives",      lives,      m_lives);
            chk("score",      score,      m_score);
            chk("ball_reset", ball_reset, m_br);
            chk("ball_start", ball_start, m_bs);
            chk("life_lost",  life_lost,  m_ll);
            chk("game_won",   game_won,   m_state == 5);
            chk("game_over",  game_over,  m_state == 4);
        end
    end

    task automatic cyc(input bit b, input bit t, input bit e, input logic [1:0] ad, input logic [9:0] y);
        btn_start = b; tick = t; erase_enable = e; active_data = ad; ball_y = y;
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        cyc(0, 0, 0, 2'd0, 10'd100);
        cyc(1, 0, 0, 2'd0, 10'd100);
        cyc(0, 0, 0, 2'd0, 10'd100);
    endtask

    initial begin
        // Button held through reset must not start a game
        reset = 1'b1;
        repeat (3) cyc(1, 0, 0, 2'd0, 10'd100);
        chk("rst_state", state, 0);
        chk("rst_ball_reset", ball_reset, 1);
        reset = 1'b0;
        repeat (3) cyc(1, 0, 0, 2'd0, 10'd100);
        chk("held_no_start", state, 0);
        cyc(0, 0, 0, 2'd0, 10'd100);
        cyc(1, 0, 0, 2'd0, 10'd100);
        chk("start_state", state, 1);
        chk("start_lives", lives, 3);
        chk("start_score", score, 0);

        // Serve: ball_start held until the first tick inclusive
        cyc(0, 0, 0, 2'd0, 10'd100);
        cyc(1, 0, 0, 2'd0, 10'd100);
        chk("serve_state", state, 2);
        chk("serve_bs", ball_start, 1);
        cyc(0, 0, 0, 2'd0, 10'd100);
        chk("serve_bs_hold", ball_start, 1);
        cyc(0, 1, 0, 2'd0, 10'd100);
        chk("serve_bs_drop", ball_start, 0);

        // Clear the whole wall; untimed erase pulses are ignored
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1, 2'd3, 10'd100);
            cyc(0, 1, 1, 2'd3, 10'd100);
            if (i == 18) chk("score_19", score, 95);
        end
        chk("won_score", score, 100);
        chk("won_state", state, 5);
        chk("won_flag", game_won, 1);
        press();
        chk("won_to_attract", state, 0);

        // Lose all lives; boundary y=473 is still in play
        press();
        press();
        cyc(0, 1, 0, 2'd0, 10'd473);
        chk("y473_no_loss", state, 2);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 2'd0, 10'd474);
            chk("loss_pulse", life_lost, 1);
            chk("loss_lives", lives, 2 - k);
            chk("loss_state", state, 3);
            cyc(0, 0, 0, 2'd0, 10'd100);
            chk("loss_pulse_end", life_lost, 0);
            repeat (59) cyc(0, 1, 0, 2'd0, 10'd100);
            chk("lost_wait", state, 3);
            cyc(0, 1, 0, 2'd0, 10'd100);
            if (k < 2) begin
                chk("reserve_state", state, 1);
                press();
            end
        end
        chk("over_state", state, 4);
        chk("over_flag", game_over, 1);
        press();

        // Last brick and ball loss on the same tick: win wins
        press();
        press();
        repeat (19) cyc(0, 1, 1, 2'd3, 10'd100);
        cyc(0, 1, 1, 2'd3, 10'd480);
        chk("tie_state", state, 5);
        chk("tie_lives", lives, 3);
        chk("tie_no_pulse", life_lost, 0);
        press();

        // Score saturation, then reset in the middle of LOST
        press();
        press();
        cyc(0, 1, 1, 2'd0, 10'd100);
        chk("ad0_ignored", score, 0);
        repeat (4093) cyc(0, 1, 1, 2'd1, 10'd100);
        chk("score_4093", score, 4093);
        cyc(0, 1, 1, 2'd3, 10'd100);
        chk("score_sat", score, 4095);
        cyc(0, 1, 1, 2'd2, 10'd100);
        chk("score_sat_hold", score, 4095);
        cyc(0, 1, 0, 2'd0, 10'd600);
        chk("sat_lost", state, 3);
        repeat (5) cyc(0, 1, 0, 2'd0, 10'd100);
        reset = 1'b1;
        cyc(0, 0, 0, 2'd0, 10'd100);
        chk("mid_lost_reset_state", state, 0);
        chk("mid_lost_reset_br", ball_reset, 1);
        chk("mid_lost_reset_score", score, 0);
        reset = 1'b0;

        // Randomized play
        for (int i = 0; i < 6000; i++) begin
            logic [9:0] y;
            case ($urandom_range(0, 9))
                0:       y = 10'($urandom_range(474, 1023));
                1:       y = 10'($urandom_range(470, 477));
                default: y = 10'($urandom_range(0, 473));
            endcase
            reset = ($urandom_range(0, 799) == 0);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), y);
        end
        reset = 1'b0;
        cyc(0, 0, 0, 2'd0, 10'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
